vga_pixel_timing: RTL and testbench
===================================

// Module: vga_pixel_timing
// PURPOSE
// - Generates VGA raster timing: HS, VS, BLANK, and aligned RGB.
// - Pulls pixels from the upstream SDRAM frame-buffer read stream with a valid/ready handshake.
// - Sits between the SDRAM read path and the vga_if signals inside fpga.
// - On underflow it never stalls the raster: it emits black and sets a sticky flag.
// PARAMETERS
// - HDISP   800  active pixels per line
// - VDISP   480  active lines per frame
// - HFP     40   horizontal front porch (pixel clocks)
// - HPULSE  48   HS pulse width
// - HBP     40   horizontal back porch
// - VFP     13   vertical front porch (lines)
// - VPULSE  3    VS pulse width (lines)
// - VBP     29   vertical back porch (lines)
// - Derived: HTOT = HDISP+HFP+HPULSE+HBP; VTOT = VDISP+VFP+VPULSE+VBP.
// - Counter widths: $clog2(HTOT) and $clog2(VTOT).
// PORTS
// - clk        in   1   pixel clock; all logic on its rising edge
// - rst        in   1   asynchronous reset, active high
// - en         in   1   raster enable; 0 holds raster in reset state
// - px_data    in   24  upstream pixel {R[7:0],G[7:0],B[7:0]}
// - px_valid   in   1   upstream has a pixel available
// - px_ready   out  1   pixel consumed this cycle (combinational)
// - vga_hs     out  1   horizontal sync, active low
// - vga_vs     out  1   vertical sync, active low
// - vga_blank  out  1   1 = displayable pixel, 0 = blanked
// - vga_sync   out  1   tied 0
// - vga_r      out  8   red
// - vga_g      out  8   green
// - vga_b      out  8   blue
// - frame_start out 1   one-cycle pulse when raster position is (0,0)
// - underflow  out  1   sticky; set when a pixel is needed but not valid
// - clr_uflow  in   1   synchronous clear of underflow
// BEHAVIOUR
// - Reset values:
//   - hcnt=0, vcnt=0
//   - vga_hs=1, vga_vs=1, vga_blank=0
//   - rgb=0, frame_start=0, underflow=0
// - Counters, when en=1:
//   - hcnt advances 0..HTOT-1 and wraps to 0.
//   - On the wrap, vcnt advances 0..VTOT-1 and wraps to 0.
// - Active region: act = (hcnt<HDISP) && (vcnt<VDISP).
// - Handshake:
//   - px_ready = en && act, combinational from the counters.
//   - A transfer occurs when px_ready && px_valid.
//   - Exactly HDISP*VDISP transfers per frame when upstream never starves.
// - Output registers (1-cycle latency; everything is delayed together so it stays aligned):
//   - vga_blank <= act.
//   - rgb <= px_valid ? px_data : 0 when act; 0 when not act.
//   - vga_hs <= !(hcnt in [HDISP+HFP, HDISP+HFP+HPULSE)).
//   - vga_vs <= !(vcnt in [VDISP+VFP, VDISP+VFP+VPULSE)).
//   - frame_start <= en && hcnt==0 && vcnt==0.
// - Underflow:
//   - Set on any cycle with px_ready && !px_valid.
//   - Cleared only by rst or clr_uflow.
//   - Set has priority over clr_uflow in the same cycle.
//   - The raster never stalls; the missing pixel is output as black.
// - en=0:
//   - Counters are forced to 0 on the next edge.
//   - Outputs take their reset values one cycle later.
//   - px_ready=0.
//   - underflow holds its value.
// - en rising: first frame_start appears 1 cycle after en is sampled high (position (0,0)).
// - Async rst mid-frame:
//   - Immediate return to reset values.
//   - Raster restarts at (0,0) after release with en=1.
//   - No partial line is resumed.
// - The upstream may present px_valid outside the active region; it is ignored (no transfer).
// TESTING
// - Test parameters: HDISP=4, VDISP=2, HFP=1, HPULSE=2, HBP=1, VFP=1, VPULSE=1, VBP=1.
// - Derived: HTOT=8, VTOT=5, 40 cycles per frame.
// - T1 reset: rst=1 for 3 cycles, en=1.
//   -> hs=1, vs=1, blank=0, rgb=0, underflow=0 throughout reset.
// - T2 timing: en=1, px_valid=1 always, run 2 frames.
//   -> hs low for hcnt 5..6 (2 cycles per line).
//   -> vs low for all of vcnt=3 (8 cycles).
//   -> blank=1 for 8 cycles per frame.
//   -> frame_start period = 40 cycles.
// - T3 data: px_data = incrementing counter from 0x000001, one value per transfer.
//   -> vga_r/g/b show 0x000001..0x000008 in raster order, one cycle after each px_ready.
//   -> Black (0) while blank=0.
// - T4 underflow: px_valid=0 during the 3rd active pixel of line 0.
//   -> that pixel is 0x000000.
//   -> underflow=1 from the next cycle.
//   -> raster period unchanged.
//   -> clr_uflow pulse returns it to 0.
//   -> underflow and clr_uflow in the same cycle -> stays 1.
// - T5 enable/reset mid-frame:
//   - Drop en at hcnt=2, vcnt=1 -> px_ready=0 at once; outputs idle within 2 cycles.
//   - Re-raise en -> frame_start after 1 cycle.
//   - Async rst pulse at an arbitrary cycle -> outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/vga_pixel_timing_if.sv
// Pixel stream from the frame-buffer read path into the VGA timing block.
// The upstream side is the master; the raster generator is the slave.
interface vga_pixel_timing_if;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready;

    modport master (
        output px_data,
        output px_valid,
        input  px_ready
    );

    modport slave (
        input  px_data,
        input  px_valid,
        output px_ready
    );
endinterface

// File: rtl/vga_pixel_timing.sv
// VGA raster timing generator: pulls pixels over valid/ready and emits HS/VS/BLANK
// with RGB aligned one cycle behind the counters; starvation yields black plus a sticky flag.
module vga_pixel_timing #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      clr_uflow_i,
    vga_pixel_timing_if.slave         px_if,
    output logic                      vga_hs_o,
    output logic                      vga_vs_o,
    output logic                      vga_blank_o,
    output logic                      vga_sync_o,
    output logic [7:0]                vga_r_o,
    output logic [7:0]                vga_g_o,
    output logic [7:0]                vga_b_o,
    output logic                      frame_start_o,
    output logic                      underflow_o
);

    localparam int HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT = VDISP + VFP + VPULSE + VBP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          blank_q, blank_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          fs_q, fs_d;
    logic          uflow_q, uflow_d;

    logic          act_s;
    logic          hwrap_s;
    logic          hpulse_s;
    logic          vpulse_s;
    logic          ready_s;

    assign act_s    = (hcnt_q < HW'(HDISP)) && (vcnt_q < VW'(VDISP));
    assign hwrap_s  = (hcnt_q == HW'(HTOT - 1));
    assign hpulse_s = (hcnt_q >= HW'(HDISP + HFP)) && (hcnt_q < HW'(HDISP + HFP + HPULSE));
    assign vpulse_s = (vcnt_q >= VW'(VDISP + VFP)) && (vcnt_q < VW'(VDISP + VFP + VPULSE));
    assign ready_s  = en_i && act_s;

    assign px_if.px_ready = ready_s;

    // Next raster position and next output word; everything is gated by en so a
    // disabled raster idles at reset values instead of replaying position (0,0).
    always_comb begin
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        hs_d    = 1'b1;
        vs_d    = 1'b1;
        blank_d = 1'b0;
        rgb_d   = 24'h000000;
        fs_d    = 1'b0;
        uflow_d = uflow_q;

        if (!en_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hwrap_s) begin
            hcnt_d = '0;
            if (vcnt_q == VW'(VTOT - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + HW'(1);
        end

        if (en_i) begin
            hs_d    = !hpulse_s;
            vs_d    = !vpulse_s;
            blank_d = act_s;
            fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
            if (act_s && px_if.px_valid) begin
                rgb_d = px_if.px_data;
            end else begin
                rgb_d = 24'h000000;
            end
        end else begin
            hs_d    = 1'b1;
            vs_d    = 1'b1;
            blank_d = 1'b0;
            fs_d    = 1'b0;
            rgb_d   = 24'h000000;
        end

        // A starved request wins over a same-cycle clear so no event is lost.
        if (ready_s && !px_if.px_valid) begin
            uflow_d = 1'b1;
        end else if (clr_uflow_i) begin
            uflow_d = 1'b0;
        end else begin
            uflow_d = uflow_q;
        end
    end

    // Raster counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= 24'h000000;
            fs_q    <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
            uflow_q <= uflow_d;
        end
    end

    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vga_blank_o   = blank_q;
    assign vga_sync_o    = 1'b0;
    assign vga_r_o       = rgb_q[23:16];
    assign vga_g_o       = rgb_q[15:8];
    assign vga_b_o       = rgb_q[7:0];
    assign frame_start_o = fs_q;
    assign underflow_o   = uflow_q;

endmodule

// File: tb/tb_vga_pixel_timing.sv
// Bench for vga_pixel_timing on a tiny 8x5 raster: a linear frame-position model
// predicts every output each cycle, plus literal checks on timing, data and underflow.
module tb_vga_pixel_timing;

    localparam int HD = 4, VD = 2, HF = 1, HP = 2, HB = 1, VF = 1, VP = 1, VB = 1;
    localparam int HT = HD + HF + HP + HB;
    localparam int VT = VD + VF + VP + VB;
    localparam int FR = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic clr = 1'b0;

    logic       vga_hs_o, vga_vs_o, vga_blank_o, vga_sync_o;
    logic [7:0] vga_r_o, vga_g_o, vga_b_o;
    logic       frame_start_o, underflow_o;

    vga_pixel_timing_if px_if ();

    vga_pixel_timing #(
        .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
        .VFP(VF), .VPULSE(VP), .VBP(VB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .clr_uflow_i  (clr),
        .px_if        (px_if.slave),
        .vga_hs_o     (vga_hs_o),
        .vga_vs_o     (vga_vs_o),
        .vga_blank_o  (vga_blank_o),
        .vga_sync_o   (vga_sync_o),
        .vga_r_o      (vga_r_o),
        .vga_g_o      (vga_g_o),
        .vga_b_o      (vga_b_o),
        .frame_start_o(frame_start_o),
        .underflow_o  (underflow_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a single position 0..FR-1 within the frame.
    int          pos     = 0;
    int          mh, mv;
    logic        ma;
    logic        m_hs    = 1'b1;
    logic        m_vs    = 1'b1;
    logic        m_blank = 1'b0;
    logic        m_fs    = 1'b0;
    logic        m_uf    = 1'b0;
    logic [23:0] m_rgb   = 24'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pos = 0; m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0;
            m_fs = 1'b0; m_uf = 1'b0; m_rgb = 24'h0;
        end else begin
            mh = pos % HT;
            mv = pos / HT;
            ma = (mh < HD) && (mv < VD);
            if (en && ma && !px_if.px_valid) m_uf = 1'b1;
            else if (clr) m_uf = 1'b0;
            if (en) begin
                m_blank = ma;
                m_rgb   = (ma && px_if.px_valid) ? px_if.px_data : 24'h0;
                m_hs    = !(mh >= HD + HF && mh < HD + HF + HP);
                m_vs    = !(mv >= VD + VF && mv < VD + VF + VP);
                m_fs    = (pos == 0);
                pos     = (pos + 1) % FR;
            end else begin
                m_blank = 1'b0; m_rgb = 24'h0; m_hs = 1'b1; m_vs = 1'b1;
                m_fs = 1'b0; pos = 0;
            end
        end
    end

    // Registered outputs checked every cycle just after the edge.
    always @(posedge clk) begin
        #1;
        check("hs", vga_hs_o, m_hs);
        check("vs", vga_vs_o, m_vs);
        check("blank", vga_blank_o, m_blank);
        check("rgb", {vga_r_o, vga_g_o, vga_b_o}, m_rgb);
        check("frame_start", frame_start_o, m_fs);
        check("underflow", underflow_o, m_uf);
        check("sync", vga_sync_o, 1'b0);
    end

    // Combinational ready checked mid-cycle after inputs settle.
    always @(negedge clk) begin
        #1;
        check("px_ready", px_if.px_ready, en && ((pos % HT) < HD) && ((pos / HT) < VD));
    end

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cnt_blank, cnt_hs, cnt_vs, cnt_fs, fs_first, fs_second, k, dcnt;

    initial begin
        px_if.px_valid = 1'b0;
        px_if.px_data  = 24'h0;

        // T1: reset held with en=1
        repeat (3) begin
            @(posedge clk);
            #1;
            check("t1_hs", vga_hs_o, 1'b1);
            check("t1_blank", vga_blank_o, 1'b0);
            check("t1_uf", underflow_o, 1'b0);
        end

        // T2: two frames with a never-starving source
        @(negedge clk);
        rst = 1'b0;
        px_if.px_valid = 1'b1;
        cnt_blank = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0; fs_first = -1; fs_second = -1;
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            px_if.px_data = 24'($urandom);
            if (vga_blank_o) cnt_blank++;
            if (!vga_hs_o) cnt_hs++;
            if (!vga_vs_o) cnt_vs++;
            if (frame_start_o) begin
                if (cnt_fs == 0) fs_first = c; else fs_second = c;
                cnt_fs++;
            end
        end
        check("t2_blank_cnt", cnt_blank, 32'd16);
        check("t2_hs_cnt", cnt_hs, 32'd20);
        check("t2_vs_cnt", cnt_vs, 32'd16);
        check("t2_fs_cnt", cnt_fs, 32'd2);
        check("t2_fs_period", fs_second - fs_first, 32'd40);

        // T3: incrementing pixel values in raster order
        @(negedge clk);
        rst = 1'b1;
        dcnt = 1;
        px_if.px_data = 24'd1;
        px_if.px_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (px_if.px_ready) dcnt++;
        k = 0;
        for (int c = 0; c < 2 * FR; c++) begin
            @(negedge clk);
            if (vga_blank_o) begin
                check("t3_pixel", {vga_r_o, vga_g_o, vga_b_o}, 32'(k + 1));
                k++;
            end else begin
                check("t3_black", {vga_r_o, vga_g_o, vga_b_o}, 32'd0);
            end
            px_if.px_data = 24'(dcnt);
            #1;
            if (px_if.px_ready) dcnt++;
        end
        check("t3_transfers", k, 32'd16);

        // T4: starve the 3rd pixel of line 0, then clear and clear-vs-set
        release_reset();
        for (int c = 1; c <= 46; c++) begin
            @(negedge clk);
            if (c == 2) check("t4_uf_before", underflow_o, 1'b0);
            if (c == 3) begin
                check("t4_uf_set", underflow_o, 1'b1);
                check("t4_black", {vga_r_o, vga_g_o, vga_b_o}, 32'd0);
                check("t4_blank", vga_blank_o, 1'b1);
            end
            if (c == 6) check("t4_uf_clr", underflow_o, 1'b0);
            if (c == 9) check("t4_uf_setwins", underflow_o, 1'b1);
            if (c == 40) check("t4_fs_early", frame_start_o, 1'b0);
            if (c == 41) check("t4_fs_period", frame_start_o, 1'b1);
            px_if.px_valid = !(c == 2 || c == 8);
            px_if.px_data  = 24'($urandom);
            clr = (c == 5 || c == 8 || c == 45);
        end
        clr = 1'b0;
        px_if.px_valid = 1'b1;

        // T5: drop en at (2,1), re-raise, then async reset mid-cycle
        release_reset();
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 10) begin
                en = 1'b0;
                #1;
                check("t5_ready_drop", px_if.px_ready, 1'b0);
            end
            if (c == 12) begin
                check("t5_idle_blank", vga_blank_o, 1'b0);
                check("t5_idle_hs", vga_hs_o, 1'b1);
            end
            if (c == 13) en = 1'b1;
            if (c == 14) check("t5_fs_after_en", frame_start_o, 1'b1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_blank", vga_blank_o, 1'b0);
        check("t5_rst_rgb", {vga_r_o, vga_g_o, vga_b_o}, 32'd0);
        check("t5_rst_hs", vga_hs_o, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Randomised run against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            px_if.px_valid = ($urandom % 4) != 0;
            px_if.px_data  = 24'($urandom);
            clr            = ($urandom % 16) == 0;
            en             = ($urandom % 64) != 0;
            if (($urandom % 400) == 0) begin
                #2 rst = 1'b1;
                #1 check("rand_rst_fs", frame_start_o, 1'b0);
                rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
